// File: rtl/segre_pkg.sv
// Shared decode-stage types: destination tags carried alongside EX/MEM/WB for hazard tracking.
package segre_pkg;

  localparam int unsigned SEGRE_REG_ADDR_W = 5;

  typedef enum logic {
    PROD_EX,
    PROD_MEM
  } prod_stage_e;

  typedef struct packed {
    logic                        valid;
    logic                        we;
    logic [SEGRE_REG_ADDR_W-1:0] rd;
    prod_stage_e                 prod_stage;
  } dep_tag_t;

  localparam dep_tag_t DEP_TAG_BUBBLE = '{valid: 1'b0, we: 1'b0, rd: '0, prod_stage: PROD_EX};

  // x0 is hardwired to zero, so a write to it never creates a dependency.
  function automatic logic tag_hits(dep_tag_t tag, logic [SEGRE_REG_ADDR_W-1:0] rs);
    return tag.valid && tag.we && (tag.rd != '0) && (tag.rd == rs);
  endfunction

endpackage

// File: rtl/dep_tag_slot.sv
// One destination-tag register: loads a new tag or a bubble when enabled, holds otherwise.
module dep_tag_slot
  import segre_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     en_i,
  input  logic     bubble_i,
  input  dep_tag_t tag_i,
  output dep_tag_t tag_o
);

  dep_tag_t tag_d, tag_q;

  always_comb begin
    tag_d = tag_q;
    if (en_i) begin
      tag_d = bubble_i ? DEP_TAG_BUBBLE : tag_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tag_q <= DEP_TAG_BUBBLE;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign tag_o = tag_q;

endmodule

// File: rtl/dep_tracker_id.sv
// Decode-stage dependency tracker: per-stage match flags for the bypass controller,
// load-use stall generation and a saturating stall-cycle counter.
module dep_tracker_id
  import segre_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = SEGRE_REG_ADDR_W,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_id_i,
  input  logic [REG_ADDR_W-1:0] rs1_id_i,
  input  logic [REG_ADDR_W-1:0] rs2_id_i,
  input  logic                  use_rs1_id_i,
  input  logic                  use_rs2_id_i,
  input  logic [REG_ADDR_W-1:0] rd_id_i,
  input  logic                  rf_we_id_i,
  input  prod_stage_e           prod_stage_id_i,
  input  logic                  mem_stall_i,
  input  logic                  flush_i,
  output logic                  valid_ex_o,
  output logic                  valid_mem_o,
  output logic                  valid_wb_o,
  output logic                  data_produced_ex_o,
  output logic                  data_produced_mem_o,
  output logic                  data_produced_wb_o,
  output logic                  depEX_src_a_o,
  output logic                  depEX_src_b_o,
  output logic                  depMEM_src_a_o,
  output logic                  depMEM_src_b_o,
  output logic                  depWB_src_a_o,
  output logic                  depWB_src_b_o,
  output logic                  stall_id_o,
  output logic [CNT_W-1:0]      stall_cycles_o
);

  dep_tag_t id_tag, ex_tag, mem_tag, wb_tag;
  logic     advance;
  logic     ex_bubble;

  logic [CNT_W-1:0] stall_cycles_d, stall_cycles_q;

  assign id_tag = '{valid: 1'b1, we: rf_we_id_i, rd: rd_id_i, prod_stage: prod_stage_id_i};

  // A memory stall freezes the whole tag pipe, including a pending flush.
  assign advance   = !mem_stall_i;
  assign ex_bubble = !(valid_id_i && !stall_id_o && !flush_i);

  dep_tag_slot u_slot_ex (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (advance),
    .bubble_i (ex_bubble),
    .tag_i    (id_tag),
    .tag_o    (ex_tag)
  );

  dep_tag_slot u_slot_mem (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (advance),
    .bubble_i (1'b0),
    .tag_i    (ex_tag),
    .tag_o    (mem_tag)
  );

  dep_tag_slot u_slot_wb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (advance),
    .bubble_i (1'b0),
    .tag_i    (mem_tag),
    .tag_o    (wb_tag)
  );

  assign valid_ex_o  = ex_tag.valid;
  assign valid_mem_o = mem_tag.valid;
  assign valid_wb_o  = wb_tag.valid;

  assign data_produced_ex_o  = ex_tag.valid && ex_tag.we && (ex_tag.prod_stage == PROD_EX);
  assign data_produced_mem_o = mem_tag.valid && mem_tag.we;
  assign data_produced_wb_o  = wb_tag.valid && wb_tag.we;

  assign depEX_src_a_o  = tag_hits(ex_tag, rs1_id_i);
  assign depEX_src_b_o  = tag_hits(ex_tag, rs2_id_i);
  assign depMEM_src_a_o = tag_hits(mem_tag, rs1_id_i);
  assign depMEM_src_b_o = tag_hits(mem_tag, rs2_id_i);
  assign depWB_src_a_o  = tag_hits(wb_tag, rs1_id_i);
  assign depWB_src_b_o  = tag_hits(wb_tag, rs2_id_i);

  // Only a load still in EX lacks its data; MEM/WB results are always bypassable.
  assign stall_id_o = valid_id_i && !flush_i && ex_tag.valid && ex_tag.we &&
                      (ex_tag.prod_stage == PROD_MEM) &&
                      ((use_rs1_id_i && depEX_src_a_o) || (use_rs2_id_i && depEX_src_b_o));

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_id_o && !mem_stall_i && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles_o = stall_cycles_q;

endmodule

// File: tb/tb_dep_tracker_id.sv
// Directed bench for dep_tracker_id: a cycle-by-cycle vector table plus hand sequences
// for memory-stall freeze, stall masking, counter saturation and mid-stream reset.
module tb_dep_tracker_id;
  import segre_pkg::*;

  localparam int unsigned CW = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           valid_id = 1'b0;
  logic [4:0]     rs1 = '0, rs2 = '0, rd = '0;
  logic           use1 = 1'b0, use2 = 1'b0, we = 1'b0;
  prod_stage_e    prod = PROD_EX;
  logic           mem_stall = 1'b0, flush = 1'b0;

  logic vex, vmem, vwb, dpex, dpmem, dpwb;
  logic dexa, dexb, dmema, dmemb, dwba, dwbb, stall;
  logic [CW-1:0] cnt;
  logic [12:0]   act_flags;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  dep_tracker_id #(.REG_ADDR_W(5), .CNT_W(CW)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .valid_id_i          (valid_id),
    .rs1_id_i            (rs1),
    .rs2_id_i            (rs2),
    .use_rs1_id_i        (use1),
    .use_rs2_id_i        (use2),
    .rd_id_i             (rd),
    .rf_we_id_i          (we),
    .prod_stage_id_i     (prod),
    .mem_stall_i         (mem_stall),
    .flush_i             (flush),
    .valid_ex_o          (vex),
    .valid_mem_o         (vmem),
    .valid_wb_o          (vwb),
    .data_produced_ex_o  (dpex),
    .data_produced_mem_o (dpmem),
    .data_produced_wb_o  (dpwb),
    .depEX_src_a_o       (dexa),
    .depEX_src_b_o       (dexb),
    .depMEM_src_a_o      (dmema),
    .depMEM_src_b_o      (dmemb),
    .depWB_src_a_o       (dwba),
    .depWB_src_b_o       (dwbb),
    .stall_id_o          (stall),
    .stall_cycles_o      (cnt)
  );

  // {vex,vmem,vwb, dpex,dpmem,dpwb, dexa,dexb, dmema,dmemb, dwba,dwbb, stall}
  assign act_flags = {vex, vmem, vwb, dpex, dpmem, dpwb, dexa, dexb, dmema, dmemb, dwba, dwbb,
                      stall};

  typedef struct {
    logic        valid;
    logic [4:0]  rs1, rs2;
    logic        u1, u2;
    logic [4:0]  rd;
    logic        we;
    logic        prod;
    logic        ms, fl;
    logic [12:0] flags;
    logic [3:0]  cnt;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(logic v, logic [4:0] a, logic [4:0] b, logic u1, logic u2,
                              logic [4:0] d, logic w, logic p, logic ms, logic fl,
                              logic [12:0] f, logic [3:0] c);
    vec_t r;
    r.valid = v; r.rs1 = a; r.rs2 = b; r.u1 = u1; r.u2 = u2; r.rd = d; r.we = w;
    r.prod = p; r.ms = ms; r.fl = fl; r.flags = f; r.cnt = c;
    return r;
  endfunction

  task automatic drive(logic v, logic [4:0] a, logic [4:0] b, logic u1, logic u2,
                       logic [4:0] d, logic w, logic p, logic ms, logic fl);
    valid_id = v; rs1 = a; rs2 = b; use1 = u1; use2 = u2; rd = d; we = w;
    prod = prod_stage_e'(p); mem_stall = ms; flush = fl;
  endtask

  task automatic check(string name, logic [12:0] ef, logic [3:0] ec);
    total++;
    if (act_flags === ef) passed++;
    else $display("FAIL %s flags: got %b expected %b", name, act_flags, ef);
    total++;
    if (cnt === ec) passed++;
    else $display("FAIL %s stall_cycles: got %0d expected %0d", name, cnt, ec);
  endtask

  initial begin
    // Continuous sequence from reset; each row is checked before its clock edge.
    vecs[0]  = mk(1, 0, 0, 0, 0, 5,  1, 0, 0, 0, 13'b000_000_00_00_00_0, 0);
    vecs[1]  = mk(1, 5, 0, 1, 0, 1,  1, 0, 0, 0, 13'b100_100_10_00_00_0, 0);
    vecs[2]  = mk(1, 5, 1, 1, 1, 7,  1, 1, 0, 0, 13'b110_110_01_10_00_0, 0);
    vecs[3]  = mk(1, 2, 7, 1, 1, 8,  1, 0, 0, 0, 13'b111_011_01_00_00_1, 0);
    vecs[4]  = mk(1, 2, 7, 1, 1, 8,  1, 0, 0, 0, 13'b011_011_00_01_00_0, 1);
    vecs[5]  = mk(1, 0, 0, 1, 1, 0,  1, 0, 0, 0, 13'b101_101_00_00_00_0, 1);
    vecs[6]  = mk(1, 0, 0, 1, 1, 0,  1, 1, 0, 0, 13'b110_110_00_00_00_0, 1);
    vecs[7]  = mk(0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 13'b111_011_00_00_00_0, 1);
    vecs[8]  = mk(1, 0, 0, 0, 0, 9,  1, 1, 0, 0, 13'b011_011_00_00_00_0, 1);
    vecs[9]  = mk(1, 9, 0, 1, 0, 10, 1, 0, 0, 1, 13'b101_001_10_00_00_0, 1);
    vecs[10] = mk(0, 9, 0, 1, 0, 0,  0, 0, 0, 0, 13'b010_010_00_10_00_0, 1);
    vecs[11] = mk(0, 9, 0, 1, 0, 0,  0, 0, 0, 0, 13'b001_001_00_00_10_0, 1);
    vecs[12] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 13'b000_000_00_00_00_0, 1);

    #2;
    check("in_reset", 13'b0, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].rd,
            vecs[i].we, vecs[i].prod, vecs[i].ms, vecs[i].fl);
      #2;
      check($sformatf("vec%0d", i), vecs[i].flags, vecs[i].cnt);
    end

    // Load x3 in EX with a 4-cycle memory stall: slots and counter frozen, stall held.
    @(negedge clk); drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 0); #2;
    check("ms_load_issue", 13'b000_000_00_00_00_0, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drive(1, 3, 0, 1, 0, 4, 1, 0, 1, 0); #2;
      check($sformatf("ms_frozen%0d", i), 13'b100_000_10_00_00_1, 1);
    end
    @(negedge clk); drive(1, 3, 0, 1, 0, 4, 1, 0, 0, 0); #2;
    check("ms_release", 13'b100_000_10_00_00_1, 1);
    @(negedge clk); #2;
    check("ms_after", 13'b010_010_00_10_00_0, 2);

    // use_rs* low masks the stall but not the dependency flags.
    @(negedge clk); drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 0); #2;
    check("mask_issue", 13'b101_101_00_00_00_0, 2);
    @(negedge clk); drive(1, 3, 3, 0, 0, 4, 1, 0, 0, 0); #2;
    check("mask_nostall", 13'b110_010_11_00_00_0, 2);

    // Flush held through a memory stall changes nothing until the stall drops.
    @(negedge clk); drive(1, 0, 0, 0, 0, 11, 1, 0, 1, 1); #2;
    check("fl_ms0", 13'b111_111_00_00_00_0, 2);
    @(negedge clk); #2;
    check("fl_ms1", 13'b111_111_00_00_00_0, 2);
    @(negedge clk); drive(1, 0, 0, 0, 0, 11, 1, 0, 0, 1); #2;
    check("fl_go", 13'b111_111_00_00_00_0, 2);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #2;
    check("fl_after", 13'b011_011_00_00_00_0, 2);
    repeat (3) @(negedge clk);

    // Repeated load-use on x7 stalls every other cycle and drives the counter to saturation.
    drive(1, 7, 0, 1, 0, 7, 1, 1, 0, 0);
    repeat (40) @(negedge clk);
    #2;
    total++;
    if (cnt === 4'd15) passed++;
    else $display("FAIL sat_count: got %0d expected 15", cnt);
    repeat (4) @(negedge clk);
    #2;
    total++;
    if (cnt === 4'd15) passed++;
    else $display("FAIL sat_hold: got %0d expected 15", cnt);
    total++;
    if ((vex | vmem) === 1'b1) passed++;
    else $display("FAIL pre_reset_busy: got vex=%b vmem=%b expected one set", vex, vmem);

    // Asynchronous reset mid-stream clears everything in the same cycle.
    #1 rst = 1'b1;
    #1;
    check("mid_reset", 13'b0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 7, 0, 1, 0, 8, 1, 0, 0, 0);
    #2;
    check("post_reset", 13'b0, 0);
    @(negedge clk); #2;
    check("post_reset_issue", 13'b100_100_00_00_00_0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
